// File: rtl/writeback_unit.sv
// Writeback stage for an RV32 pipeline: retires ALU results in one cycle and
// holds load instructions until the memory response arrives, then performs
// byte/halfword/word extraction with sign or zero extension.
module writeback_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_reg_write,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [31:0] write_data,
  output logic [4:0]  write_destination,
  output logic        write_enable,
  output logic        busy
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned OFF_W     = 2;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Captured load context, held while the response is outstanding
  logic [REG_IDX_W-1:0] ld_rd;
  logic [F3_W-1:0]      ld_funct3;
  logic [OFF_W-1:0]     ld_offset;
  logic                 ld_reg_write;

  logic                 load_accept;
  logic                 wb_fire;
  logic                 wb_we_d;
  logic [XLEN-1:0]      wb_data_d;
  logic [REG_IDX_W-1:0] wb_dest_d;

  // Select the addressed byte/halfword and extend it according to funct3
  function automatic logic [XLEN-1:0] extract_load(
    input logic [F3_W-1:0]  f3,
    input logic [OFF_W-1:0] off,
    input logic [XLEN-1:0]  word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b100:  extract_load = {24'd0, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b101:  extract_load = {16'd0, h};
      default: extract_load = word;
    endcase
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (ex_valid && ex_is_load) state_next = LOAD_WAIT;
      LOAD_WAIT: if (mem_rsp_valid)          state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Handshake, status and next writeback values
  always_comb begin
    ex_ready    = 1'b0;
    busy        = 1'b0;
    load_accept = 1'b0;
    wb_fire     = 1'b0;
    wb_we_d     = 1'b0;
    wb_data_d   = write_data;
    wb_dest_d   = write_destination;
    case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid) begin
          if (ex_is_load) begin
            load_accept = 1'b1;
          end else begin
            wb_fire   = 1'b1;
            wb_we_d   = ex_reg_write && (ex_rd != '0);
            wb_data_d = ex_result;
            wb_dest_d = ex_rd;
          end
        end
      end
      LOAD_WAIT: begin
        busy = 1'b1;
        if (mem_rsp_valid) begin
          wb_fire   = 1'b1;
          wb_we_d   = ld_reg_write && (ld_rd != '0);
          wb_data_d = extract_load(ld_funct3, ld_offset, mem_rsp_data);
          wb_dest_d = ld_rd;
        end
      end
      default: ;
    endcase
  end

  // Load context capture on an accepted load
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_rd        <= '0;
      ld_funct3    <= '0;
      ld_offset    <= '0;
      ld_reg_write <= 1'b0;
    end else if (load_accept) begin
      ld_rd        <= ex_rd;
      ld_funct3    <= ex_funct3;
      ld_offset    <= ex_result[OFF_W-1:0];
      ld_reg_write <= ex_reg_write;
    end
  end

  // Registered register-file write port; data/index hold between completions
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable      <= 1'b0;
      write_data        <= '0;
      write_destination <= '0;
    end else begin
      write_enable <= wb_we_d;
      if (wb_fire) begin
        write_data        <= wb_data_d;
        write_destination <= wb_dest_d;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vectors plus randomized
// ALU and load traffic compared against a behavioural model.
module tb_writeback_unit;

  logic        clock;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic        ex_reg_write;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] write_data;
  logic [4:0]  write_destination;
  logic        write_enable;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_data;
  logic [4:0]  exp_dest;

  writeback_unit dut (
    .clock             (clock),
    .reset             (reset),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .ex_rd             (ex_rd),
    .ex_result         (ex_result),
    .ex_is_load        (ex_is_load),
    .ex_funct3         (ex_funct3),
    .ex_reg_write      (ex_reg_write),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .write_data        (write_data),
    .write_destination (write_destination),
    .write_enable      (write_enable),
    .busy              (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference load extraction from the ISA rules using plain arithmetic
  function automatic logic [31:0] ref_load(input int f3, input int addr, input logic [31:0] word);
    longint unsigned w;
    longint unsigned v;
    w = longint'(word);
    if (f3 == 0 || f3 == 4) begin
      v = (w / (longint'(1) << (8 * addr))) % 256;
      if (f3 == 0 && v >= 128) v = v + 64'hFFFFFF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (w / (longint'(1) << (16 * (addr / 2)))) % 65536;
      if (f3 == 1 && v >= 32768) v = v + 64'hFFFF0000;
    end else begin
      v = w;
    end
    return 32'(v);
  endfunction

  task automatic clear_inputs();
    ex_valid      = 1'b0;
    ex_rd         = '0;
    ex_result     = '0;
    ex_is_load    = 1'b0;
    ex_funct3     = '0;
    ex_reg_write  = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    ex_valid = 1'b1; ex_rd = 5'd3; ex_result = 32'h1234_5678; ex_reg_write = 1'b1;
    tick();
    tick();
    checks++;
    if (write_enable !== 1'b0 || write_data !== 32'h0 || write_destination !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs: we=%b data=%h dest=%0d required we=0 data=0 dest=0",
               write_enable, write_data, write_destination);
    end
    checks++;
    if (busy !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_status: busy=%b ready=%b required busy=0 ready=1", busy, ex_ready);
    end
    reset = 1'b0;
    clear_inputs();
    tick();
    checks++;
    if (write_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_after: we=%b required 0", write_enable);
    end
    exp_data = 32'h0;
    exp_dest = 5'd0;
  endtask

  task automatic test_alu();
    ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'hDEAD_BEEF; ex_reg_write = 1'b1; ex_is_load = 1'b0;
    tick();
    clear_inputs();
    checks++;
    if (write_enable !== 1'b1 || write_destination !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL alu_directed: we=%b dest=%0d data=%h required we=1 dest=5 data=deadbeef",
               write_enable, write_destination, write_data);
    end
    tick();
    checks++;
    if (write_enable !== 1'b0 || write_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL alu_pulse_end: we=%b data=%h required we=0 data=deadbeef", write_enable, write_data);
    end
    exp_data = 32'hDEAD_BEEF;
    exp_dest = 5'd5;
    for (int i = 0; i < 20; i++) begin
      logic exp_we;
      ex_valid     = 1'b1;
      ex_is_load   = 1'b0;
      ex_rd        = 5'($urandom_range(0, 31));
      ex_result    = $urandom;
      ex_funct3    = 3'($urandom_range(0, 7));
      ex_reg_write = 1'($urandom_range(0, 1));
      exp_we   = ex_reg_write && (ex_rd != 5'd0);
      exp_data = ex_result;
      exp_dest = ex_rd;
      tick();
      clear_inputs();
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_data  = $urandom;
      checks++;
      if (write_enable !== exp_we || write_data !== exp_data || write_destination !== exp_dest) begin
        failures++;
        $display("FAIL alu_random[%0d]: we=%b data=%h dest=%0d required we=%b data=%h dest=%0d",
                 i, write_enable, write_data, write_destination, exp_we, exp_data, exp_dest);
      end
      tick();
      checks++;
      if (write_enable !== 1'b0 || write_data !== exp_data || write_destination !== exp_dest
          || busy !== 1'b0) begin
        failures++;
        $display("FAIL alu_idle_hold[%0d]: we=%b data=%h dest=%0d busy=%b required we=0 data=%h dest=%0d busy=0",
                 i, write_enable, write_data, write_destination, busy, exp_data, exp_dest);
      end
      clear_inputs();
    end
  endtask

  task automatic test_x0();
    ex_valid = 1'b1; ex_rd = 5'd0; ex_result = 32'hDEAD_BEEF; ex_reg_write = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (write_enable !== 1'b0 || write_destination !== 5'd0 || write_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL x0_write: we=%b dest=%0d data=%h required we=0 dest=0 data=deadbeef",
               write_enable, write_destination, write_data);
    end
    exp_data = 32'hDEAD_BEEF;
    exp_dest = 5'd0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      logic exp_we;
      ex_valid     = 1'b1;
      ex_is_load   = 1'b0;
      ex_rd        = 5'($urandom_range(1, 31));
      ex_result    = $urandom;
      ex_reg_write = 1'b1;
      exp_we   = 1'b1;
      exp_data = ex_result;
      exp_dest = ex_rd;
      tick();
      checks++;
      if (write_enable !== exp_we || write_data !== exp_data || write_destination !== exp_dest
          || ex_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d]: we=%b data=%h dest=%0d ready=%b required we=1 data=%h dest=%0d ready=1",
                 i, write_enable, write_data, write_destination, ex_ready, exp_data, exp_dest);
      end
    end
    clear_inputs();
    tick();
    checks++;
    if (write_enable !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: we=%b required 0", write_enable);
    end
  endtask

  task automatic test_loads();
    // Directed vectors: {funct3, addr, response, expected, delay}
    int          d_f3   [6] = '{0, 4, 1, 5, 2, 2};
    logic [31:0] d_addr [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102, 32'h100};
    logic [31:0] d_rsp  [6] = '{32'h80FF1234, 32'h80FF1234, 32'h80017FFF, 32'h80017FFF,
                                32'h80017FFF, 32'h0BAD_F00D};
    logic [31:0] d_exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                32'h80017FFF, 32'h0BAD_F00D};
    int          d_dly  [6] = '{0, 1, 0, 2, 0, 3};

    // A response while idle must never produce a write
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001;
    tick();
    clear_inputs();
    checks++;
    if (write_enable !== 1'b0 || busy !== 1'b0 || write_data !== exp_data) begin
      failures++;
      $display("FAIL stray_rsp: we=%b busy=%b data=%h required we=0 busy=0 data=%h",
               write_enable, busy, write_data, exp_data);
    end

    for (int i = 0; i < 30; i++) begin
      int          f3;
      int          dly;
      int          busy_cycles;
      logic [31:0] addr;
      logic [31:0] rsp;
      logic [31:0] want;
      logic [4:0]  rd;
      logic        rw;
      logic        exp_we;
      if (i < 6) begin
        f3 = d_f3[i]; addr = d_addr[i]; rsp = d_rsp[i]; want = d_exp[i]; dly = d_dly[i];
        rd = 5'(i + 10); rw = 1'b1;
      end else begin
        f3   = $urandom_range(0, 7);
        addr = $urandom;
        rsp  = $urandom;
        dly  = $urandom_range(0, 4);
        rd   = 5'($urandom_range(0, 31));
        rw   = 1'($urandom_range(0, 1));
        want = ref_load(f3, int'(addr % 4), rsp);
      end
      exp_we = rw && (rd != 5'd0);

      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_result = addr;
      ex_funct3 = 3'(f3); ex_reg_write = rw;
      tick();
      // Keep offering a different instruction; it must be stalled
      ex_is_load = 1'b0; ex_rd = 5'd31; ex_result = 32'h5555_AAAA; ex_reg_write = 1'b1;
      checks++;
      if (write_enable !== 1'b0 || busy !== 1'b1 || ex_ready !== 1'b0 || write_data !== exp_data) begin
        failures++;
        $display("FAIL load_accept[%0d]: we=%b busy=%b ready=%b data=%h required we=0 busy=1 ready=0 data=%h",
                 i, write_enable, busy, ex_ready, write_data, exp_data);
      end
      busy_cycles = 1;
      for (int k = 0; k < dly; k++) begin
        tick();
        if (busy === 1'b1 && ex_ready === 1'b0 && write_enable === 1'b0) busy_cycles++;
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = rsp;
      tick();
      clear_inputs();
      checks++;
      if (busy_cycles != dly + 1) begin
        failures++;
        $display("FAIL load_wait[%0d]: stalled_cycles=%0d required %0d", i, busy_cycles, dly + 1);
      end
      exp_data = want;
      exp_dest = rd;
      checks++;
      if (write_enable !== exp_we || write_data !== want || write_destination !== rd
          || busy !== 1'b0 || ex_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_result[%0d]: f3=%0d addr=%h we=%b data=%h dest=%0d busy=%b ready=%b required we=%b data=%h dest=%0d busy=0 ready=1",
                 i, f3, addr, write_enable, write_data, write_destination, busy, ex_ready,
                 exp_we, want, rd);
      end
      tick();
      checks++;
      if (write_enable !== 1'b0 || write_data !== exp_data) begin
        failures++;
        $display("FAIL load_pulse_end[%0d]: we=%b data=%h required we=0 data=%h",
                 i, write_enable, write_data, exp_data);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; ex_result = 32'h200;
    ex_funct3 = 3'b010; ex_reg_write = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_enter: busy=%b required 1", busy);
    end
    reset = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
    tick();
    reset = 1'b0;
    mem_rsp_data = 32'h3333_4444;
    checks++;
    if (busy !== 1'b0 || ex_ready !== 1'b1 || write_enable !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state: busy=%b ready=%b we=%b required busy=0 ready=1 we=0",
               busy, ex_ready, write_enable);
    end
    tick();
    clear_inputs();
    checks++;
    if (write_enable !== 1'b0 || write_data !== 32'h0 || write_destination !== 5'd0
        || ex_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_rsp: we=%b data=%h dest=%0d ready=%b busy=%b required we=0 data=0 dest=0 ready=1 busy=0",
               write_enable, write_data, write_destination, ex_ready, busy);
    end
    tick();
    checks++;
    if (write_enable !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_after: we=%b required 0", write_enable);
    end
    exp_data = 32'h0;
    exp_dest = 5'd0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    exp_data = 32'h0;
    exp_dest = 5'd0;
    test_reset();
    test_alu();
    test_x0();
    test_back_to_back();
    test_loads();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameters SHALL be none; all widths SHALL be fixed for RV32 (XLEN 32, 5-bit register index).
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 ex_valid  input  1  SHALL mean an execute-stage result is offered.
REQ-005 ex_ready  output  1  SHALL mean the unit accepts the offered result this cycle.
REQ-006 ex_rd  input  5  SHALL be the destination register index.
REQ-007 ex_result  input  32  SHALL be the ALU result, or the load byte address when ex_is_load=1.
REQ-008 ex_is_load  input  1  SHALL mark the offered instruction as a load.
REQ-009 ex_funct3  input  3  SHALL be the load width/sign code (instruction[14:12]).
REQ-010 ex_reg_write  input  1  SHALL mean the instruction writes a register.
REQ-011 mem_rsp_valid  input  1  SHALL mark mem_rsp_data as valid.
REQ-012 mem_rsp_data  input  32  SHALL be the word-aligned data word read from memory.
REQ-013 write_data  output  32  SHALL be the register-file write data.
REQ-014 write_destination  output  5  SHALL be the register-file write index.
REQ-015 write_enable  output  1  SHALL be the register-file write strobe.
REQ-016 busy  output  1  SHALL be high while a load response is outstanding.

Function
REQ-017 The FSM SHALL have two states, IDLE and LOAD_WAIT; busy SHALL equal (state==LOAD_WAIT).
REQ-018 ex_ready SHALL be 1 in IDLE and 0 in LOAD_WAIT, combinationally from state.
REQ-019 Handshake: a transfer SHALL occur only when ex_valid and ex_ready are both 1.
REQ-020 Non-load transfer: the cycle after the transfer, write_enable SHALL be 1, write_data=ex_result, write_destination=ex_rd; the state SHALL stay IDLE.
REQ-021 Load transfer: the unit SHALL capture ex_rd, ex_funct3, ex_result[1:0] and ex_reg_write, then enter LOAD_WAIT on the next edge; no write SHALL occur on that edge.
REQ-022 In LOAD_WAIT with mem_rsp_valid=1, the unit SHALL write the extracted load value on the next cycle and return to IDLE on the same edge.
- ex_ready SHALL therefore reassert in the same cycle write_enable pulses.
REQ-023 In LOAD_WAIT with mem_rsp_valid=0, the unit SHALL hold state with no write, for any number of cycles.
REQ-024 mem_rsp_valid in IDLE SHALL be ignored.
REQ-025 Load extraction:
- byte lane = addr[1:0]*8; halfword lane = addr[1]*16, with addr[0] ignored.
- funct3 000 LB: sign-extend byte. 100 LBU: zero-extend byte.
- 001 LH: sign-extend half. 101 LHU: zero-extend half.
- 010 LW and codes 011, 110, 111: full word.
REQ-026 write_enable SHALL be forced to 0 when the captured reg_write=0 or rd=0; write_data and write_destination SHALL still update.
REQ-027 write_enable SHALL be a single-cycle pulse per accepted instruction; it SHALL be 0 on every cycle with no completing instruction.
REQ-028 write_data and write_destination SHALL be registered and SHALL hold their last values when write_enable=0.
REQ-029 Total latency SHALL be 1 cycle for non-loads, and 1 cycle after mem_rsp_valid for loads.

Reset
REQ-030 On reset, the unit SHALL set state=IDLE, write_enable=0, write_data=0 and write_destination=0, and clear all captured load fields.
REQ-031 Reset SHALL take priority over any transfer or response in the same cycle.
REQ-032 Reset in LOAD_WAIT SHALL discard the pending load; a later mem_rsp_valid SHALL cause no write.

Verification
REQ-033 ALU: ex_valid=1, rd=5, result=0xDEADBEEF, reg_write=1 -> next cycle: we=1, dest=5, data=0xDEADBEEF; following cycle: we=0.
REQ-034 x0: same as REQ-033 with rd=0 -> we stays 0; write_destination=0, write_data=0xDEADBEEF.
REQ-035 Byte loads: addr=0x103, rsp=0x80FF1234:
- LB -> data=0xFFFFFF80.
- LBU -> data=0x00000080.
REQ-036 Half loads: addr=0x102, rsp=0x80017FFF:
- LH -> data=0xFFFF8001.
- LHU -> data=0x00008001.
- LW -> data=0x80017FFF.
REQ-037 Delayed response: load accepted, rsp arrives 3 cycles later -> busy=1 and ex_ready=0 for 4 cycles, then one we pulse; a stray rsp pulse in IDLE before the load -> no write.
REQ-038 Reset mid-load: reset asserted in LOAD_WAIT, rsp given the next cycle -> state IDLE, we never asserts, ex_ready=1.
